// File: rtl/pwm_dac_driver_if.sv
// Sample handshake between the sine producer and the PWM DAC driver.
// The producer uses the master modport, the driver the slave modport.
interface pwm_dac_driver_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] in_sample;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_sample,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_sample,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/pwm_dac_driver.sv
// Single-pin PWM DAC: shadow-buffered samples, duty swapped only at period boundaries.
// Optional macro PWM_DAC_UNDERRUN_CNT_EN adds a saturating underrun counter with a clear input.
module pwm_dac_driver #(
    parameter int WIDTH    = 10,
    parameter int PRESCALE = 1
) (
    input  logic               clk,
    input  logic               rst,
    pwm_dac_driver_if.slave    bus,
    output logic               pwm_out,
    output logic               period_start,
    output logic               underrun,
    output logic               running
`ifdef PWM_DAC_UNDERRUN_CNT_EN
    ,
    input  logic               underrun_clr,
    output logic [15:0]        underrun_count
`endif
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = '1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   cnt;
    logic [PRE_W-1:0]   pre;
    logic [WIDTH-1:0]   active;
    logic [WIDTH-1:0]   shadow;
    logic               shadow_full;

    logic tick;
    logic boundary;
    logic accept;

    // in_ready comes straight from the shadow_full flop, so the producer never
    // sees a combinational path from its own in_valid.
    assign bus.in_ready = ~shadow_full;
    assign accept       = bus.in_valid && !shadow_full;
    assign tick         = (pre == PRE_LAST);
    assign boundary     = (state == RUN) && tick && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            pre          <= '0;
            active       <= '0;
            shadow       <= '0;
            shadow_full  <= 1'b0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            underrun     <= 1'b0;
            running      <= 1'b0;
`ifdef PWM_DAC_UNDERRUN_CNT_EN
            underrun_count <= '0;
`endif
        end else begin
            // NOTE: all state here uses <= so every branch sees pre-edge values;
            // blocking assignments would make the result depend on statement order.
            period_start <= 1'b0;
            pwm_out      <= (state == RUN) && (cnt < active);

            case (state)
                IDLE: begin
                    cnt <= '0;
                    pre <= '0;
                    if (accept) begin
                        // First sample bypasses the shadow and starts period 1 at once.
                        active       <= bus.in_sample;
                        state        <= RUN;
                        running      <= 1'b1;
                        period_start <= 1'b1;
                    end
                end

                RUN: begin
                    pre <= tick ? '0 : pre + 1'b1;
                    if (tick) begin
                        cnt <= cnt + 1'b1;
                    end

                    if (boundary) begin
                        period_start <= 1'b1;
                        if (shadow_full) begin
                            active      <= shadow;
                            shadow_full <= 1'b0;
                        end else begin
                            // Repeat the last duty; a sample arriving now waits a full period.
                            underrun <= 1'b1;
                            if (accept) begin
                                shadow      <= bus.in_sample;
                                shadow_full <= 1'b1;
                            end
                        end
                    end else if (accept) begin
                        shadow      <= bus.in_sample;
                        shadow_full <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase

`ifdef PWM_DAC_UNDERRUN_CNT_EN
            if (underrun_clr) begin
                underrun_count <= '0;
                underrun       <= 1'b0;
            end else if (boundary && !shadow_full && (underrun_count != 16'hFFFF)) begin
                underrun_count <= underrun_count + 16'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_pwm_dac_driver.sv
// Bench for pwm_dac_driver: two instances (PRESCALE 1 and 4) checked every cycle
// against a time-arithmetic reference model, plus duty tables and corner sequences.
module tb_pwm_dac_driver;

    localparam int W = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       v_in = '0;
    logic [W-1:0]     s_in [2];
    logic [1:0]       pwm_o, ps_o, ur_o, run_o, rdy_o;
`ifdef PWM_DAC_UNDERRUN_CNT_EN
    logic [1:0]       clr_in = '0;
    logic [15:0]      ucnt_o [2];
`endif

    int cyc    = 0;
    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    pwm_dac_driver_if #(.WIDTH(W)) bus_a ();
    pwm_dac_driver_if #(.WIDTH(W)) bus_b ();

    assign bus_a.in_sample = s_in[0];
    assign bus_a.in_valid  = v_in[0];
    assign rdy_o[0]        = bus_a.in_ready;
    assign bus_b.in_sample = s_in[1];
    assign bus_b.in_valid  = v_in[1];
    assign rdy_o[1]        = bus_b.in_ready;

    pwm_dac_driver #(.WIDTH(W), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .pwm_out(pwm_o[0]), .period_start(ps_o[0]), .underrun(ur_o[0]), .running(run_o[0])
`ifdef PWM_DAC_UNDERRUN_CNT_EN
        , .underrun_clr(clr_in[0]), .underrun_count(ucnt_o[0])
`endif
    );

    pwm_dac_driver #(.WIDTH(W), .PRESCALE(4)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .pwm_out(pwm_o[1]), .period_start(ps_o[1]), .underrun(ur_o[1]), .running(run_o[1])
`ifdef PWM_DAC_UNDERRUN_CNT_EN
        , .underrun_clr(clr_in[1]), .underrun_count(ucnt_o[1])
`endif
    );

    // Reference model: position in the period is derived from elapsed cycles since
    // RUN began; duty per period comes from the current/pending sample pair.
    typedef struct {
        bit running;
        int t0;
        int duty;
        bit pend;
        int pend_val;
        bit underrun;
        int ucount;
        bit pwm;
        bit pstart;
    } model_t;

    model_t m [2];

    function automatic int pscale(int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int period_len(int d);
        return pscale(d) * (1 << W);
    endfunction

    task automatic model_edge(int d);
        int ph;
        bit bnd;
        if (rst) begin
            m[d] = '{default: 0};
            return;
        end
        if (!m[d].running) begin
            m[d].pwm    = 1'b0;
            m[d].pstart = 1'b0;
            if (v_in[d]) begin
                m[d].running = 1'b1;
                m[d].t0      = cyc;
                m[d].duty    = int'(s_in[d]);
                m[d].pstart  = 1'b1;
            end
        end else begin
            ph          = (cyc - 1 - m[d].t0) % period_len(d);
            m[d].pwm    = (ph / pscale(d)) < m[d].duty;
            bnd         = (ph == period_len(d) - 1);
            m[d].pstart = bnd;
            if (bnd) begin
                if (m[d].pend) begin
                    m[d].duty = m[d].pend_val;
                    m[d].pend = 1'b0;
                end else begin
                    m[d].underrun = 1'b1;
                    if (m[d].ucount < 65535) m[d].ucount++;
                    if (v_in[d]) begin
                        m[d].pend     = 1'b1;
                        m[d].pend_val = int'(s_in[d]);
                    end
                end
            end else if (v_in[d] && !m[d].pend) begin
                m[d].pend     = 1'b1;
                m[d].pend_val = int'(s_in[d]);
            end
        end
`ifdef PWM_DAC_UNDERRUN_CNT_EN
        if (clr_in[d]) begin
            m[d].underrun = 1'b0;
            m[d].ucount   = 0;
        end
`endif
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge(0);
        model_edge(1);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("outs_dut%0d{pwm,ps,ur,run,rdy}", d),
                  32'({pwm_o[d], ps_o[d], ur_o[d], run_o[d], rdy_o[d]}),
                  32'({m[d].pwm, m[d].pstart, m[d].underrun, m[d].running, ~m[d].pend}));
`ifdef PWM_DAC_UNDERRUN_CNT_EN
            check($sformatf("underrun_count_dut%0d", d), 32'(ucnt_o[d]), 32'(m[d].ucount));
`endif
        end
    endtask

    task automatic apply_reset();
        rst  = 1'b1;
        v_in = '0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic accept(int d, int sample);
        v_in[d] = 1'b1;
        s_in[d] = W'(sample);
        step();
        v_in[d] = 1'b0;
    endtask

    // Runs one full period starting on a period_start cycle; optionally feeds one sample.
    task automatic run_period(input int d, input int feed_step, input int feed_val,
                              output int highs, output int first, output int rdy_low,
                              output int end_ps);
        highs   = 0;
        first   = 0;
        rdy_low = 0;
        for (int i = 0; i < period_len(d); i++) begin
            if (i == feed_step) begin
                v_in[d] = 1'b1;
                s_in[d] = W'(feed_val);
            end
            step();
            v_in[d] = 1'b0;
            if (pwm_o[d]) highs++;
            if (!rdy_o[d]) rdy_low++;
            if (i == 0) first = int'(pwm_o[d]);
        end
        end_ps = int'(ps_o[d]);
    endtask

    typedef struct {
        int d;
        int sample;
        int exp_high;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int h, f, rl, e, pulses, highs;

        tbl[0] = '{0, 256, 256};
        tbl[1] = '{0, 0, 0};
        tbl[2] = '{0, 1023, 1023};
        tbl[3] = '{1, 3, 12};
        tbl[4] = '{1, 0, 0};
        tbl[5] = '{1, 1023, 4092};
        s_in[0] = '0;
        s_in[1] = '0;

        // Reset, then long idle with no samples.
        apply_reset();
        pulses = 0;
        highs  = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            pulses += int'(ps_o[0]) + int'(ps_o[1]);
            highs  += int'(pwm_o[0]) + int'(pwm_o[1]);
        end
        check("idle_period_start_pulses", 32'(pulses), 0);
        check("idle_pwm_high_cycles", 32'(highs), 0);
        check("idle_running", 32'(run_o), 0);
        check("idle_in_ready", 32'(rdy_o), 32'(2'b11));

        // Duty table: sample refreshed every period, steady-state high count per period.
        for (int k = 0; k < 6; k++) begin
            apply_reset();
            accept(tbl[k].d, tbl[k].sample);
            check($sformatf("tbl%0d_first_period_start", k), 32'(ps_o[tbl[k].d]), 1);
            run_period(tbl[k].d, 1, tbl[k].sample, h, f, rl, e);
            check($sformatf("tbl%0d_p1_highs", k), 32'(h), 32'(tbl[k].exp_high));
            check($sformatf("tbl%0d_p1_first_pwm", k), 32'(f), 32'(tbl[k].exp_high > 0));
            check($sformatf("tbl%0d_p1_boundary", k), 32'(e), 1);
            run_period(tbl[k].d, 1, tbl[k].sample, h, f, rl, e);
            check($sformatf("tbl%0d_p2_highs", k), 32'(h), 32'(tbl[k].exp_high));
            check($sformatf("tbl%0d_p2_low", k), 32'(period_len(tbl[k].d) - h),
                  32'(period_len(tbl[k].d) - tbl[k].exp_high));
            check($sformatf("tbl%0d_underrun", k), 32'(ur_o[tbl[k].d]), 0);
        end

        // 100 then 900 fed early: shadow holds 900 until the boundary.
        apply_reset();
        accept(0, 100);
        run_period(0, 3, 900, h, f, rl, e);
        check("swap_p1_highs", 32'(h), 100);
        check("swap_p1_ready_low_cycles", 32'(rl), 32'(1024 - 1 - 3));
        check("swap_ready_after_boundary", 32'(rdy_o[0]), 1);
        run_period(0, -1, 0, h, f, rl, e);
        check("swap_p2_highs", 32'(h), 900);

        // Starved producer: underrun after first boundary, duty repeats.
        apply_reset();
        accept(0, 512);
        run_period(0, -1, 0, h, f, rl, e);
        check("starve_p1_highs", 32'(h), 512);
        check("starve_underrun_after_b1", 32'(ur_o[0]), 1);
        run_period(0, -1, 0, h, f, rl, e);
        check("starve_p2_highs", 32'(h), 512);
        run_period(0, -1, 0, h, f, rl, e);
`ifdef PWM_DAC_UNDERRUN_CNT_EN
        check("starve_count_after_b3", 32'(ucnt_o[0]), 3);
        clr_in[0] = 1'b1;
        step();
        clr_in[0] = 1'b0;
        check("starve_count_after_clr", 32'(ucnt_o[0]), 0);
        check("starve_flag_after_clr", 32'(ur_o[0]), 0);
`else
        step();
        check("starve_underrun_sticky", 32'(ur_o[0]), 1);
`endif

        // Reset mid-period with a pending shadow sample.
        apply_reset();
        accept(0, 300);
        repeat (10) step();
        accept(0, 700);
        check("midrst_shadow_full", 32'(rdy_o[0]), 0);
        repeat (200) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_pwm", 32'(pwm_o[0]), 0);
        check("midrst_ready", 32'(rdy_o[0]), 1);
        check("midrst_running", 32'(run_o[0]), 0);
        accept(0, 40);
        check("midrst_restart_running", 32'(run_o[0]), 1);
        check("midrst_restart_period_start", 32'(ps_o[0]), 1);
        run_period(0, -1, 0, h, f, rl, e);
        check("midrst_restart_highs", 32'(h), 40);

        // Randomized traffic on both instances against the model.
        apply_reset();
        for (int i = 0; i < 8000; i++) begin
            rst     = ($urandom_range(0, 2999) == 0);
            v_in[0] = ($urandom_range(0, 399) == 0);
            v_in[1] = ($urandom_range(0, 1999) == 0);
            for (int d = 0; d < 2; d++) begin
                case ($urandom_range(0, 3))
                    0:       s_in[d] = '0;
                    1:       s_in[d] = '1;
                    default: s_in[d] = W'($urandom);
                endcase
            end
`ifdef PWM_DAC_UNDERRUN_CNT_EN
            clr_in[0] = ($urandom_range(0, 1499) == 0);
            clr_in[1] = ($urandom_range(0, 1499) == 0);
`endif
            step();
        end
        rst  = 1'b0;
        v_in = '0;
`ifdef PWM_DAC_UNDERRUN_CNT_EN
        clr_in = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the cycle budget");
        $fatal(1, "watchdog expired");
    end

endmodule
